// File: rtl/sal_rd_resp.sv
// sal_rd_resp: in-order DFI read data return onto AXI R with credit-based command flow control
module sal_rd_resp #(
  parameter int DATA_W = 64,
  parameter int ID_W = 4,
  parameter int BURST_LEN = 4,
  parameter int TAG_DEPTH = 8,
  parameter int DATA_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_cmd_valid,
  input  logic [ID_W-1:0]   rd_cmd_id,
  output logic              rd_cmd_ready,
  input  logic              dfi_rddata_valid,
  input  logic [DATA_W-1:0] dfi_rddata,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [ID_W-1:0]   axi_rid,
  output logic [DATA_W-1:0] axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rlast,
  output logic              err_ovf,
  output logic              err_spur
);
  localparam int TW = $clog2(TAG_DEPTH);
  localparam int DW = $clog2(DATA_DEPTH);
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [DW:0] BL = (DW+1)'(BURST_LEN);
  localparam logic [DW:0] DD = (DW+1)'(DATA_DEPTH);
  logic [ID_W-1:0] tag_mem [TAG_DEPTH];
  logic [DATA_W-1:0] dat_mem [DATA_DEPTH];
  logic [TW:0] tw_ptr, tr_ptr;
  logic [DW:0] dw_ptr, dr_ptr, reserved, rx_pend;
  logic [BW-1:0] beat;
  logic tag_full, dat_full, acc, pop, cand, push;
  assign tag_full = tw_ptr[TW] != tr_ptr[TW] && tw_ptr[TW-1:0] == tr_ptr[TW-1:0];
  assign dat_full = dw_ptr[DW] != dr_ptr[DW] && dw_ptr[DW-1:0] == dr_ptr[DW-1:0];
  assign rd_cmd_ready = !rst && !tag_full && reserved <= DD - BL;
  assign axi_rvalid = !rst && dw_ptr != dr_ptr;
  assign axi_rdata = dat_mem[dr_ptr[DW-1:0]];
  assign axi_rid = tag_mem[tr_ptr[TW-1:0]];
  assign axi_rresp = 2'b00;
  assign axi_rlast = axi_rvalid && beat == BW'(BURST_LEN - 1);
  assign acc = rd_cmd_valid && rd_cmd_ready;
  assign pop = axi_rvalid && axi_rready;
  assign cand = dfi_rddata_valid && rx_pend != '0;
  assign push = cand && (!dat_full || pop);
  always_ff @(posedge clk) begin
    if (acc) tag_mem[tw_ptr[TW-1:0]] <= rd_cmd_id;
    if (push) dat_mem[dw_ptr[DW-1:0]] <= dfi_rddata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tw_ptr <= '0;
      tr_ptr <= '0;
      dw_ptr <= '0;
      dr_ptr <= '0;
      reserved <= '0;
      rx_pend <= '0;
      beat <= '0;
      err_ovf <= 1'b0;
      err_spur <= 1'b0;
    end else begin
      if (acc) tw_ptr <= tw_ptr + 1'b1;
      if (pop && axi_rlast) tr_ptr <= tr_ptr + 1'b1;
      if (push) dw_ptr <= dw_ptr + 1'b1;
      if (pop) dr_ptr <= dr_ptr + 1'b1;
      if (pop) beat <= beat + 1'b1;
      reserved <= reserved + (acc ? BL : '0) - {{DW{1'b0}}, pop && reserved != '0};
      rx_pend <= rx_pend + (acc ? BL : '0) - {{DW{1'b0}}, cand};
      err_ovf <= err_ovf || (cand && !push);
      err_spur <= err_spur || (dfi_rddata_valid && rx_pend == '0);
    end
  end
endmodule

// File: doc/sal_rd_resp.md
SAL_RD_RESP -- requirements
Module: sal_rd_resp

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 64, DFI/AXI read data width
- ID_W, 4, AXI ID width
- BURST_LEN, 4, DFI data beats per read command, power of 2, at least 2
- TAG_DEPTH, 8, outstanding read command tags, power of 2
- DATA_DEPTH, 32, read data buffer entries, power of 2, at least BURST_LEN

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- rd_cmd_valid  in  1  scheduler has issued a DRAM RD command
- rd_cmd_id  in  ID_W  AXI ID of that read
- rd_cmd_ready  out  1  block can accept a command
- dfi_rddata_valid  in  1  PHY read beat valid; cannot be stalled
- dfi_rddata  in  DATA_W  PHY read beat
- axi_rvalid  out  1  R channel valid
- axi_rready  in  1  R channel ready
- axi_rid  out  ID_W  R channel ID
- axi_rdata  out  DATA_W  R channel data
- axi_rresp  out  2  R channel response
- axi_rlast  out  1  last beat of the burst
- err_ovf  out  1  sticky: beat dropped, data buffer full
- err_spur  out  1  sticky: beat arrived with no pending command

Function
REQ-003 A command SHALL be accepted in a cycle where rd_cmd_valid and rd_cmd_ready are both 1; rd_cmd_id SHALL be pushed into an in-order tag FIFO of TAG_DEPTH entries.
REQ-004 rd_cmd_ready SHALL be 1 iff the tag FIFO is not full and reserved + BURST_LEN <= DATA_DEPTH.
- reserved = data beats committed and not yet handshaken on R.
REQ-005 reserved SHALL change by +BURST_LEN on each command accept and by -1 on each R handshake.
- Both in the same cycle: net change is BURST_LEN-1.
- reserved SHALL NOT underflow.
REQ-006 A counter rx_pend SHALL track beats expected from DFI.
- +BURST_LEN on command accept.
- -1 on each accepted DFI beat.
REQ-007 A dfi_rddata_valid beat SHALL be written to the data FIFO when rx_pend (as of the start of the cycle) is nonzero and the FIFO is not full.
- A beat that arrives in the same cycle as a command accept, with rx_pend = 0, SHALL be flagged spurious.
REQ-008 A beat arriving with rx_pend = 0 SHALL be dropped and SHALL set err_spur.
REQ-009 A beat arriving with rx_pend > 0 while the data FIFO is full and no pop occurs that cycle SHALL be dropped, SHALL set err_ovf, and SHALL still decrement rx_pend.
- Push and pop in the same cycle on a full FIFO: the push is accepted.
REQ-010 R channel outputs:
- axi_rvalid SHALL be 1 iff the data FIFO is not empty.
- axi_rdata SHALL be the FIFO head.
- axi_rid SHALL be the tag FIFO head.
- axi_rresp SHALL be 2'b00.
REQ-011 A beat counter SHALL count R handshakes modulo BURST_LEN.
- axi_rlast SHALL be 1 when the counter equals BURST_LEN-1.
- The tag FIFO SHALL pop on the handshake with axi_rlast = 1.
REQ-012 While axi_rvalid is 1 and axi_rready is 0, axi_rdata, axi_rid and axi_rlast SHALL hold stable.
REQ-013 Latency: a beat written at DFI cycle N SHALL appear on R no earlier than cycle N+1, and at cycle N+1 when the FIFO was empty.
REQ-014 Ordering: read data SHALL be returned strictly in command order; IDs SHALL NOT be reordered.
REQ-015 FIFO pointers SHALL wrap modulo depth, using an extra MSB to distinguish full from empty.
REQ-016 err_ovf and err_spur SHALL stay set until reset.

Reset
REQ-017 While rst is 1 at a clock edge, the block SHALL:
- empty both FIFOs;
- clear reserved, rx_pend and the beat counter to 0;
- clear err_ovf and err_spur to 0;
- drive axi_rvalid = 0 and axi_rlast = 0;
- drive rd_cmd_ready = 0 during reset, then 1 from the first cycle after rst deasserts.
REQ-018 Reset asserted mid-burst SHALL discard all buffered data and tags; no R beat SHALL be presented in the cycle after reset.

Verification
REQ-019 Single read: command with id=3, then 4 DFI beats D0..D3 two cycles later, rready=1.
- Expect 4 R beats with rid=3, data D0..D3, rlast only on D3, first beat one cycle after D0.
REQ-020 Back-pressure: two commands (id=1, id=2), 8 beats, rready held 0 for 20 cycles then released.
- Expect R outputs stable while stalled, then 8 beats in order, IDs 1,1,1,1,2,2,2,2.
- Expect reserved = 8 while stalled.
REQ-021 Credit limit: DATA_DEPTH=32, BURST_LEN=4, rready=0, issue commands continuously.
- Expect exactly 8 accepted, then rd_cmd_ready=0.
- Expect ready to return 1 in the cycle after 4 R handshakes.
REQ-022 Spurious beat: dfi_rddata_valid with no command outstanding.
- Expect err_spur=1 next cycle, axi_rvalid remains 0.
REQ-023 Simultaneous events: command accept, DFI beat and R handshake in one cycle.
- Expect reserved net +3, rx_pend net +3, no error flags.
REQ-024 Reset mid-burst: rst asserted after 2 of 4 beats have been delivered.
- Expect axi_rvalid=0, all counters 0, err flags 0.
- A fresh command after reset completes normally.
